// File: rtl/poly_phasor.sv
// Time-multiplexed N-voice phase accumulator: one Enable tick runs a frame that
// services every voice in turn, one per Clk, emitting wavetable address/fraction.
//
// state | meaning
// IDLE  | waiting for a sample tick (Enable or a pending tick)
// RUN   | servicing voice voiceSel this cycle
module poly_phasor #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 12,
  parameter int INTERP_W   = 16,
  localparam int VW        = $clog2(NUM_VOICES)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [PHASE_W-1:0]  phaseIncrement,
  input  logic [PHASE_W-1:0]  fmInput,
  input  logic                phaseRst,
  output logic [VW-1:0]       voiceSel,
  output logic                busy,
  output logic                outValid,
  output logic [VW-1:0]       voiceOut,
  output logic [ADDR_W-1:0]   wavetableAddr,
  output logic [INTERP_W-1:0] interp,
  output logic                wrapped,
  output logic                frameDone,
  output logic                overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic   pending;
  logic   last_voice;

  logic [PHASE_W-1:0] phase [NUM_VOICES];
  logic [PHASE_W+1:0] sum;
  logic               wrap_now;

  assign last_voice = (voiceSel == VW'(NUM_VOICES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Enable || pending) state_d = RUN;
      RUN:     if (last_voice && !pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // A frame start consumes the pending tick; a fresh Enable in that same cycle
  // becomes the new pending tick rather than being lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      voiceSel <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Enable || pending) begin
            voiceSel <= '0;
            pending  <= pending & Enable;
          end
        end
        RUN: begin
          if (last_voice) voiceSel <= '0;
          else            voiceSel <= voiceSel + VW'(1);
          if (last_voice && pending) begin
            pending <= Enable;
          end else if (Enable) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Two guard bits: bit PHASE_W+1 flags a negative sum, bit PHASE_W an overflow.
  always_comb begin
    sum = {2'b00, phase[voiceSel]}
        + {2'b00, phaseIncrement}
        + {{2{fmInput[PHASE_W-1]}}, fmInput};
    wrap_now = sum[PHASE_W+1] | sum[PHASE_W];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
      outValid      <= 1'b0;
      voiceOut      <= '0;
      wavetableAddr <= '0;
      interp        <= '0;
      wrapped       <= 1'b0;
      frameDone     <= 1'b0;
    end else begin
      outValid  <= 1'b0;
      wrapped   <= 1'b0;
      frameDone <= 1'b0;
      if (busy) begin
        phase[voiceSel] <= phaseRst ? '0 : sum[PHASE_W-1:0];
        outValid        <= 1'b1;
        voiceOut        <= voiceSel;
        wavetableAddr   <= phaseRst ? '0 : phase[voiceSel][PHASE_W-1 -: ADDR_W];
        interp          <= phaseRst ? '0 : phase[voiceSel][PHASE_W-ADDR_W-1 -: INTERP_W];
        wrapped         <= ~phaseRst & wrap_now;
        frameDone       <= last_voice;
      end
    end
  end

endmodule
